// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the integer reservation station.
//   - default operand/tag/opcode widths used as parameter defaults
//   - rs_entry_t: packed view of one station slot at the default widths
//   - rs_opcode_e: integer ALU operation encoding carried in the opcode field
package rs_pkg;

    localparam int unsigned RS_XLEN  = 32;
    localparam int unsigned RS_TAG_W = 6;
    localparam int unsigned RS_OP_W  = 5;

    typedef enum logic [RS_OP_W-1:0] {
        OpAdd  = 5'h00,
        OpSub  = 5'h01,
        OpAnd  = 5'h02,
        OpOr   = 5'h03,
        OpXor  = 5'h04,
        OpSll  = 5'h05,
        OpSrl  = 5'h06,
        OpSra  = 5'h07,
        OpSlt  = 5'h08,
        OpSltu = 5'h09
    } rs_opcode_e;

    typedef struct packed {
        logic                valid;
        logic [RS_OP_W-1:0]  opcode;
        logic [RS_TAG_W-1:0] rd_tag;
        logic [RS_TAG_W-1:0] rs1_tag;
        logic [RS_TAG_W-1:0] rs2_tag;
        logic [RS_XLEN-1:0]  rs1_data;
        logic [RS_XLEN-1:0]  rs2_data;
        logic                rs1_val;
        logic                rs2_val;
    } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot.
// Next state is chosen as dispatch-load (highest priority), shift-from-above, or hold;
// the CDB wakeup is then applied to whichever source was chosen, so a shifted entry keeps
// a wakeup from the same edge and a freshly dispatched operand gets same-cycle forwarding.
// Ports:
//   clk, reset          clock, synchronous active-high clear
//   load_en, shift_en   load from dispatch / take the entry from the slot above
//   up_*                contents of the slot above (all zero for the top slot)
//   dsp_*               dispatch fields
//   cdb_*               common data bus broadcast
//   valid..rs2_val      registered slot contents
module rs_entry import rs_pkg::*; #(
    parameter int unsigned XLEN  = RS_XLEN,
    parameter int unsigned TAG_W = RS_TAG_W,
    parameter int unsigned OP_W  = RS_OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             up_valid,
    input  logic [OP_W-1:0]  up_opcode,
    input  logic [TAG_W-1:0] up_rd_tag,
    input  logic [TAG_W-1:0] up_rs1_tag,
    input  logic [TAG_W-1:0] up_rs2_tag,
    input  logic [XLEN-1:0]  up_rs1_data,
    input  logic [XLEN-1:0]  up_rs2_data,
    input  logic             up_rs1_val,
    input  logic             up_rs2_val,
    input  logic [OP_W-1:0]  dsp_opcode,
    input  logic [TAG_W-1:0] dsp_rd_tag,
    input  logic [TAG_W-1:0] dsp_rs1_tag,
    input  logic [TAG_W-1:0] dsp_rs2_tag,
    input  logic [XLEN-1:0]  dsp_rs1_data,
    input  logic [XLEN-1:0]  dsp_rs2_data,
    input  logic             dsp_rs1_val,
    input  logic             dsp_rs2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             valid,
    output logic [OP_W-1:0]  opcode,
    output logic [TAG_W-1:0] rd_tag,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs1_val,
    output logic             rs2_val
);

    logic             valid_d;
    logic [OP_W-1:0]  opcode_d;
    logic [TAG_W-1:0] rd_tag_d, rs1_tag_d, rs2_tag_d;
    logic [XLEN-1:0]  rs1_data_d, rs2_data_d;
    logic             rs1_val_d, rs2_val_d;

    always_comb begin
        valid_d    = valid;
        opcode_d   = opcode;
        rd_tag_d   = rd_tag;
        rs1_tag_d  = rs1_tag;
        rs2_tag_d  = rs2_tag;
        rs1_data_d = rs1_data;
        rs2_data_d = rs2_data;
        rs1_val_d  = rs1_val;
        rs2_val_d  = rs2_val;
        if (load_en) begin
            valid_d    = 1'b1;
            opcode_d   = dsp_opcode;
            rd_tag_d   = dsp_rd_tag;
            rs1_tag_d  = dsp_rs1_tag;
            rs2_tag_d  = dsp_rs2_tag;
            rs1_data_d = dsp_rs1_data;
            rs2_data_d = dsp_rs2_data;
            rs1_val_d  = dsp_rs1_val;
            rs2_val_d  = dsp_rs2_val;
        end else if (shift_en) begin
            valid_d    = up_valid;
            opcode_d   = up_opcode;
            rd_tag_d   = up_rd_tag;
            rs1_tag_d  = up_rs1_tag;
            rs2_tag_d  = up_rs2_tag;
            rs1_data_d = up_rs1_data;
            rs2_data_d = up_rs2_data;
            rs1_val_d  = up_rs1_val;
            rs2_val_d  = up_rs2_val;
        end
        // Wakeup applies after source selection; already-valid operands ignore the bus.
        if (valid_d && !rs1_val_d && cdb_valid && (rs1_tag_d == cdb_tag)) begin
            rs1_data_d = cdb_data;
            rs1_val_d  = 1'b1;
        end
        if (valid_d && !rs2_val_d && cdb_valid && (rs2_tag_d == cdb_tag)) begin
            rs2_data_d = cdb_data;
            rs2_val_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            opcode   <= '0;
            rd_tag   <= '0;
            rs1_tag  <= '0;
            rs2_tag  <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            rs1_val  <= 1'b0;
            rs2_val  <= 1'b0;
        end else begin
            valid    <= valid_d;
            opcode   <= opcode_d;
            rd_tag   <= rd_tag_d;
            rs1_tag  <= rs1_tag_d;
            rs2_tag  <= rs2_tag_d;
            rs1_data <= rs1_data_d;
            rs2_data <= rs2_data_d;
            rs1_val  <= rs1_val_d;
            rs2_val  <= rs2_val_d;
        end
    end

endmodule

// File: rtl/param_reservation_station.sv
// param_reservation_station: DEPTH-entry integer reservation station, slot 0 oldest.
// Accepts one dispatch per cycle (with same-cycle CDB forwarding), wakes operands from the
// CDB, and presents one ready op per cycle to the execution block; the issued slot is
// removed and the slots above it compact down by one.
// Build option: define RS_OLDEST_READY_EN for oldest-ready-first selection over all slots;
// without it only slot 0 may issue (in-order).
// Ports:
//   clk, reset                          clock, synchronous active-high clear
//   dispatch_*                          dispatch request and op fields
//   issueque_full, issueque_count       occupancy (registered)
//   cdb_valid, cdb_tag, cdb_data        result broadcast
//   issueque_ready, issueque_*          selected op (zero when none ready)
//   issueblk_done                       execution block accepts the presented op
module param_reservation_station import rs_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = RS_XLEN,
    parameter int unsigned TAG_W = RS_TAG_W,
    parameter int unsigned OP_W  = RS_OP_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_enable,
    input  logic [XLEN-1:0]            dispatch_rs1_data,
    input  logic [XLEN-1:0]            dispatch_rs2_data,
    input  logic [TAG_W-1:0]           dispatch_rs1_tag,
    input  logic [TAG_W-1:0]           dispatch_rs2_tag,
    input  logic                       dispatch_rs1_data_val,
    input  logic                       dispatch_rs2_data_val,
    input  logic [OP_W-1:0]            dispatch_opcode,
    input  logic [TAG_W-1:0]           dispatch_rd_tag,
    output logic                       issueque_full,
    output logic [$clog2(DEPTH+1)-1:0] issueque_count,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       issueque_ready,
    output logic [XLEN-1:0]            issueque_rs1_data,
    output logic [XLEN-1:0]            issueque_rs2_data,
    output logic [TAG_W-1:0]           issueque_rd_tag,
    output logic [OP_W-1:0]            issueque_opcode,
    input  logic                       issueblk_done
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    logic             e_valid    [DEPTH];
    logic [OP_W-1:0]  e_opcode   [DEPTH];
    logic [TAG_W-1:0] e_rd_tag   [DEPTH];
    logic [TAG_W-1:0] e_rs1_tag  [DEPTH];
    logic [TAG_W-1:0] e_rs2_tag  [DEPTH];
    logic [XLEN-1:0]  e_rs1_data [DEPTH];
    logic [XLEN-1:0]  e_rs2_data [DEPTH];
    logic             e_rs1_val  [DEPTH];
    logic             e_rs2_val  [DEPTH];

    logic [CW-1:0] count_q;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          issue;
    logic          accept;
    logic [CW-1:0] dsp_slot;

`ifdef RS_OLDEST_READY_EN
    // Scan from the top so the lowest-index ready slot wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_valid[i] && e_rs1_val[i] && e_rs2_val[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end
`else
    assign sel_found = e_valid[0] && e_rs1_val[0] && e_rs2_val[0];
    assign sel_idx   = '0;
`endif

    assign issueque_full  = (count_q == CW'(DEPTH));
    assign issueque_count = count_q;
    assign accept         = dispatch_enable && !issueque_full;
    assign issue          = sel_found && issueblk_done;
    // Removal compacts everything down by one, so the free slot moves down with it.
    assign dsp_slot       = issue ? (count_q - CW'(1)) : count_q;

    assign issueque_ready    = sel_found;
    assign issueque_rs1_data = sel_found ? e_rs1_data[sel_idx] : '0;
    assign issueque_rs2_data = sel_found ? e_rs2_data[sel_idx] : '0;
    assign issueque_rd_tag   = sel_found ? e_rd_tag[sel_idx]   : '0;
    assign issueque_opcode   = sel_found ? e_opcode[sel_idx]   : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             up_valid;
        logic [OP_W-1:0]  up_opcode;
        logic [TAG_W-1:0] up_rd_tag, up_rs1_tag, up_rs2_tag;
        logic [XLEN-1:0]  up_rs1_data, up_rs2_data;
        logic             up_rs1_val, up_rs2_val;

        if (i == DEPTH - 1) begin : g_top
            assign up_valid    = 1'b0;
            assign up_opcode   = '0;
            assign up_rd_tag   = '0;
            assign up_rs1_tag  = '0;
            assign up_rs2_tag  = '0;
            assign up_rs1_data = '0;
            assign up_rs2_data = '0;
            assign up_rs1_val  = 1'b0;
            assign up_rs2_val  = 1'b0;
        end else begin : g_mid
            assign up_valid    = e_valid[i+1];
            assign up_opcode   = e_opcode[i+1];
            assign up_rd_tag   = e_rd_tag[i+1];
            assign up_rs1_tag  = e_rs1_tag[i+1];
            assign up_rs2_tag  = e_rs2_tag[i+1];
            assign up_rs1_data = e_rs1_data[i+1];
            assign up_rs2_data = e_rs2_data[i+1];
            assign up_rs1_val  = e_rs1_val[i+1];
            assign up_rs2_val  = e_rs2_val[i+1];
        end

        rs_entry #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .OP_W  (OP_W)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .load_en      (accept && (dsp_slot == CW'(i))),
            .shift_en     (issue && (sel_idx <= IW'(i))),
            .up_valid     (up_valid),
            .up_opcode    (up_opcode),
            .up_rd_tag    (up_rd_tag),
            .up_rs1_tag   (up_rs1_tag),
            .up_rs2_tag   (up_rs2_tag),
            .up_rs1_data  (up_rs1_data),
            .up_rs2_data  (up_rs2_data),
            .up_rs1_val   (up_rs1_val),
            .up_rs2_val   (up_rs2_val),
            .dsp_opcode   (dispatch_opcode),
            .dsp_rd_tag   (dispatch_rd_tag),
            .dsp_rs1_tag  (dispatch_rs1_tag),
            .dsp_rs2_tag  (dispatch_rs2_tag),
            .dsp_rs1_data (dispatch_rs1_data),
            .dsp_rs2_data (dispatch_rs2_data),
            .dsp_rs1_val  (dispatch_rs1_data_val),
            .dsp_rs2_val  (dispatch_rs2_data_val),
            .cdb_valid    (cdb_valid),
            .cdb_tag      (cdb_tag),
            .cdb_data     (cdb_data),
            .valid        (e_valid[i]),
            .opcode       (e_opcode[i]),
            .rd_tag       (e_rd_tag[i]),
            .rs1_tag      (e_rs1_tag[i]),
            .rs2_tag      (e_rs2_tag[i]),
            .rs1_data     (e_rs1_data[i]),
            .rs2_data     (e_rs2_data[i]),
            .rs1_val      (e_rs1_val[i]),
            .rs2_val      (e_rs2_val[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(accept) - CW'(issue);
        end
    end

endmodule

// File: tb/tb_param_reservation_station.sv
// Bench for param_reservation_station: directed scenarios followed by random traffic.
// A reference model (age-ordered queue of ops) predicts the presented op and occupancy for
// every cycle; predictions are queued and a separate monitor compares them against the DUT.
module tb_param_reservation_station;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dispatch_enable = 1'b0;
    logic [31:0] dispatch_rs1_data = '0, dispatch_rs2_data = '0;
    logic [5:0]  dispatch_rs1_tag = '0, dispatch_rs2_tag = '0;
    logic        dispatch_rs1_data_val = 1'b0, dispatch_rs2_data_val = 1'b0;
    logic [4:0]  dispatch_opcode = '0;
    logic [5:0]  dispatch_rd_tag = '0;
    logic        issueque_full;
    logic [2:0]  issueque_count;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        issueque_ready;
    logic [31:0] issueque_rs1_data, issueque_rs2_data;
    logic [5:0]  issueque_rd_tag;
    logic [4:0]  issueque_opcode;
    logic        issueblk_done = 1'b0;

    param_reservation_station #(
        .DEPTH (DEPTH),
        .XLEN  (32),
        .TAG_W (6),
        .OP_W  (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dispatch_enable       (dispatch_enable),
        .dispatch_rs1_data     (dispatch_rs1_data),
        .dispatch_rs2_data     (dispatch_rs2_data),
        .dispatch_rs1_tag      (dispatch_rs1_tag),
        .dispatch_rs2_tag      (dispatch_rs2_tag),
        .dispatch_rs1_data_val (dispatch_rs1_data_val),
        .dispatch_rs2_data_val (dispatch_rs2_data_val),
        .dispatch_opcode       (dispatch_opcode),
        .dispatch_rd_tag       (dispatch_rd_tag),
        .issueque_full         (issueque_full),
        .issueque_count        (issueque_count),
        .cdb_valid             (cdb_valid),
        .cdb_tag               (cdb_tag),
        .cdb_data              (cdb_data),
        .issueque_ready        (issueque_ready),
        .issueque_rs1_data     (issueque_rs1_data),
        .issueque_rs2_data     (issueque_rs2_data),
        .issueque_rd_tag       (issueque_rd_tag),
        .issueque_opcode       (issueque_opcode),
        .issueblk_done         (issueblk_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en;
        logic [4:0]  op;
        logic [5:0]  rd, t1, t2;
        logic [31:0] d1, d2;
        logic        v1, v2;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        done;
    } stim_t;

    typedef struct {
        logic [4:0]  op;
        logic [5:0]  rd, t1, t2;
        logic [31:0] d1, d2;
        logic        v1, v2;
    } mop_t;

    typedef struct {
        logic        rdy;
        logic [31:0] a, b;
        logic [5:0]  rd;
        logic [4:0]  op;
        int          cnt;
        logic        full;
    } exp_t;

    mop_t mq[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, en: 1'b0, op: '0, rd: '0, t1: '0, t2: '0, d1: '0, d2: '0,
              v1: 1'b0, v2: 1'b0, cv: 1'b0, ct: '0, cd: '0, done: 1'b0};
        return s;
    endfunction

    // Index of the op the station should present, or -1.
    function automatic int model_sel();
`ifdef RS_OLDEST_READY_EN
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].v1 && mq[i].v2) return i;
        return -1;
`else
        if (mq.size() > 0 && mq[0].v1 && mq[0].v2) return 0;
        return -1;
`endif
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   k;
        k = model_sel();
        e = '{rdy: 1'b0, a: '0, b: '0, rd: '0, op: '0, cnt: mq.size(),
              full: (mq.size() == DEPTH)};
        if (k >= 0) begin
            e.rdy = 1'b1;
            e.a   = mq[k].d1;
            e.b   = mq[k].d2;
            e.rd  = mq[k].rd;
            e.op  = mq[k].op;
        end
        return e;
    endfunction

    task automatic step(input stim_t s);
        int   k;
        bit   acc;
        mop_t m;
        @(negedge clk);
        exp_q.push_back(model_expect());
        reset                 = s.rst;
        dispatch_enable       = s.en;
        dispatch_opcode       = s.op;
        dispatch_rd_tag       = s.rd;
        dispatch_rs1_tag      = s.t1;
        dispatch_rs2_tag      = s.t2;
        dispatch_rs1_data     = s.d1;
        dispatch_rs2_data     = s.d2;
        dispatch_rs1_data_val = s.v1;
        dispatch_rs2_data_val = s.v2;
        cdb_valid             = s.cv;
        cdb_tag               = s.ct;
        cdb_data              = s.cd;
        issueblk_done         = s.done;
        if (s.rst) begin
            mq.delete();
        end else begin
            k   = model_sel();
            acc = s.en && (mq.size() < DEPTH);
            if (k >= 0 && s.done) mq.delete(k);
            if (s.cv) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].v1 && mq[i].t1 == s.ct) begin mq[i].d1 = s.cd; mq[i].v1 = 1'b1; end
                    if (!mq[i].v2 && mq[i].t2 == s.ct) begin mq[i].d2 = s.cd; mq[i].v2 = 1'b1; end
                end
            end
            if (acc) begin
                m = '{op: s.op, rd: s.rd, t1: s.t1, t2: s.t2, d1: s.d1, d2: s.d2,
                      v1: s.v1, v2: s.v2};
                if (!m.v1 && s.cv && m.t1 == s.ct) begin m.d1 = s.cd; m.v1 = 1'b1; end
                if (!m.v2 && s.cv && m.t2 == s.ct) begin m.d2 = s.cd; m.v2 = 1'b1; end
                mq.push_back(m);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare the DUT's presented state against each queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", 32'(issueque_ready), 32'(e.rdy));
                chk("count", 32'(issueque_count), 32'(e.cnt));
                chk("full", 32'(issueque_full), 32'(e.full));
                chk("rs1_data", issueque_rs1_data, e.a);
                chk("rs2_data", issueque_rs2_data, e.b);
                chk("rd_tag", 32'(issueque_rd_tag), 32'(e.rd));
                chk("opcode", 32'(issueque_opcode), 32'(e.op));
            end
        end
    end

    initial begin
        stim_t s;
        repeat (2) @(posedge clk);

        // Basic dispatch with both operands valid, then issue it.
        s = idle(); s.en = 1; s.op = 5'h03; s.d1 = 32'h10; s.v1 = 1; s.d2 = 32'h20; s.v2 = 1;
        s.rd = 6'd9; step(s);
        step(idle());
        s = idle(); s.done = 1; step(s);
        step(idle());

        // rs1 pending on tag 12, woken by the CDB.
        s = idle(); s.en = 1; s.op = 5'h01; s.rd = 6'd2; s.t1 = 6'd12; s.d2 = 32'h5; s.v2 = 1;
        step(s);
        step(idle());
        s = idle(); s.cv = 1; s.ct = 6'd12; s.cd = 32'hABCD; step(s);
        step(idle());
        s = idle(); s.done = 1; step(s);

        // Forwarding at dispatch on rs2.
        s = idle(); s.en = 1; s.op = 5'h02; s.rd = 6'd4; s.d1 = 32'h1; s.v1 = 1; s.t2 = 6'd7;
        s.cv = 1; s.ct = 6'd7; s.cd = 32'h55; step(s);
        step(idle());
        s = idle(); s.done = 1; step(s);

        // Fill with slots 0/1 pending and 2.. ready; full-queue dispatch is refused.
        s = idle(); s.rst = 1; step(s);
        for (int i = 0; i < DEPTH; i++) begin
            s = idle(); s.en = 1; s.op = 5'(i + 8); s.rd = 6'(i + 1); s.t1 = 6'(20 + i);
            s.v1 = (i >= 2); s.d1 = 32'(100 + i); s.d2 = 32'(200 + i); s.v2 = 1;
            step(s);
        end
        step(idle());
        s = idle(); s.en = 1; s.op = 5'h1f; s.v1 = 1; s.v2 = 1; step(s);
        s.done = 1; step(s);
        step(idle());
        s = idle(); s.cv = 1; s.ct = 6'd20; s.cd = 32'h2020; step(s);
        s = idle(); s.cv = 1; s.ct = 6'd21; s.cd = 32'h2121; step(s);
        for (int i = 0; i < DEPTH + 2; i++) begin s = idle(); s.done = 1; step(s); end

        // Reset mid-stream with pending ops; a later broadcast must wake nothing.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.en = 1; s.rd = 6'(i); s.t1 = 6'd30; s.v2 = 1; s.d2 = 32'(i); step(s);
        end
        s = idle(); s.rst = 1; s.cv = 1; s.ct = 6'd30; s.cd = 32'h77; step(s);
        s = idle(); s.cv = 1; s.ct = 6'd30; s.cd = 32'h78; step(s);
        step(idle());
        step(idle());

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 299) == 0);
            s.en   = ($urandom_range(0, 99) < 55);
            s.op   = 5'($urandom);
            s.rd   = 6'($urandom);
            s.v1   = 1'($urandom);
            s.v2   = 1'($urandom);
            s.t1   = 6'($urandom_range(0, 7));
            s.t2   = 6'($urandom_range(0, 7));
            s.d1   = $urandom;
            s.d2   = $urandom;
            s.cv   = ($urandom_range(0, 99) < 45);
            s.ct   = 6'($urandom_range(0, 7));
            s.cd   = $urandom;
            s.done = ($urandom_range(0, 99) < 60);
            step(s);
        end

        // Drain: broadcast every tag and accept everything.
        for (int c = 0; c < 40; c++) begin
            s = idle(); s.cv = 1; s.ct = 6'(c % 8); s.cd = $urandom; s.done = 1; step(s);
        end
        step(idle());

        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_reservation_station.md
# param_reservation_station

Parametrised integer reservation station: holds up to DEPTH dispatched ops, wakes operands from the common data bus (CDB), and issues one ready op per cycle to the integer execution block. It sits between dispatch and the integer ALU and replaces the fixed 4-entry, head-only station. New over the previous generation:
- configurable depth and widths
- same-cycle CDB forwarding at dispatch
- oldest-ready-first issue from any slot, with compaction

## Interface
Parameters:
- DEPTH, 4: number of entries, ≥2
- XLEN, 32: operand data width
- TAG_W, 6: ROB/rename tag width
- OP_W, 5: opcode width

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all entries on the clk edge where it is high
- dispatch_enable  in  1  dispatch request
- dispatch_rs1_data / dispatch_rs2_data  in  XLEN  operand values
- dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W  producer tags
- dispatch_rs1_data_val / dispatch_rs2_data_val  in  1  operand already valid
- dispatch_opcode  in  OP_W  operation
- dispatch_rd_tag  in  TAG_W  destination tag
- issueque_full  out  1  count == DEPTH
- issueque_count  out  $clog2(DEPTH+1)  occupied entries
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  XLEN  broadcast value
- issueque_ready  out  1  an issuable entry exists
- issueque_rs1_data / issueque_rs2_data  out  XLEN  selected entry operands
- issueque_rd_tag  out  TAG_W  selected entry destination
- issueque_opcode  out  OP_W  selected entry opcode
- issueblk_done  in  1  execution block accepts the presented op this cycle

## Operation
- Entry fields: valid, opcode, rd_tag, rs1/rs2 tag, data, data_valid. Entries are compacted, with slot 0 the oldest.
- Dispatch accepted iff dispatch_enable && !issueque_full. The op is written to slot count, or count−1 if an issue occurs the same cycle. A dispatch while full is ignored (no state change) and must not be relied on.
- Dispatch forwarding: for each operand with data_val=0, cdb_valid=1 and tag==cdb_tag, store cdb_data with data_valid=1.
- Wakeup: each valid entry whose operand is not valid and tag==cdb_tag with cdb_valid captures cdb_data and sets data_valid. Already-valid operands ignore the CDB.
- Ready entry: valid && rs1 data_valid && rs2 data_valid.
- Selection: the lowest-index ready entry. issueque_ready=1 if one exists. Outputs show that entry combinationally; all outputs are 0 when none is ready.
- Issue occurs when issueque_ready && issueblk_done. The selected slot is removed at the edge, and slots above it shift down by one while keeping any wakeup captured that same edge. issueblk_done without ready is ignored.
- count updates as +accepted_dispatch − issue.

## Timing
- Reset values: issueque_full=0, issueque_count=0, issueque_ready=0, all data/tag/opcode outputs 0. All entry valid bits are cleared, and a reset mid-operation discards every pending op.
- Dispatch with both operands valid (directly or via forwarding): issueque_ready=1 the next cycle.
- CDB broadcast at cycle N: the woken entry is ready at N+1. No same-cycle CDB→issue bypass.
- Issue is zero-latency combinational select; removal takes effect at the accepting edge.
- Simultaneous dispatch + issue + CDB in one cycle: all three are applied; the shift and wakeup are merged into the same slot.
- With full and issue in the same cycle, dispatch is still refused, because full is evaluated from registered count.

## Configuration
- RS_OLDEST_READY_EN defined: oldest-ready-first selection over all slots, as above.
- RS_OLDEST_READY_EN undefined: in-order. Only slot 0 is considered: issueque_ready = slot0 ready; removal always shifts from slot 0. This gives smaller logic for area-limited builds.

## Structure
- Package rs_pkg: default XLEN/TAG_W/OP_W constants, the rs_entry_t packed struct, and the integer opcode enum.
- Sub-module rs_entry: one slot register with its next-state mux (hold / shift-from-above / dispatch-load), CDB tag compare and capture. It is instantiated DEPTH times by generate. The top holds the priority select, the count and the output mux.

## Test plan
- Reset, then dispatch opcode 5'h03, rs1=32'h10 valid, rs2=32'h20 valid, rd=6'd9 → next cycle ready=1, outputs 10/20/9/03, count=1.
- Dispatch rs1 pending on tag 6'd12, then cdb_valid with tag 12, data 32'hABCD → ready=1 one cycle after the CDB, rs1_data=ABCD.
- Dispatch with rs2 tag 6'd7 pending while cdb_valid, tag 7, data 32'h55 in the same cycle → entry ready next cycle, rs2_data=55.
- Fill DEPTH entries, with slot 0 pending and slot 2 ready (EN defined) → slot 2 issued first, count DEPTH−1, slots 3..DEPTH−1 shifted to 2..; EN undefined → ready=0 until slot 0 wakes.
- Full queue plus dispatch_enable → ignored, count stays DEPTH. Full plus issue plus dispatch in one cycle → issue only, count DEPTH−1.
- Assert reset mid-stream with 3 entries and pending CDB → next cycle all outputs 0, count 0, and a later CDB wakes nothing.
